// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel/coordinate types and RGB332 expansion.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [7:0]  rgb332_t;
  typedef logic [10:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication so full-scale 3/2-bit codes map to 8'hFF.
  function automatic rgb888_t rgb332_to_888(input rgb332_t c);
    rgb888_t o;
    o.r = {c[7:5], c[7:5], c[7:6]};
    o.g = {c[4:2], c[4:2], c[4:3]};
    o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; each bit resets to its own preload value.
module vga_delay_line #(
  parameter int unsigned          DEPTH = 1,
  parameter int unsigned          WIDTH = 1,
  parameter logic [WIDTH-1:0]     INIT  = '0
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= INIT;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster counters, sync/blank generation aligned to the object layer
// latency, RGB332 pixel output stage and a per-frame tick.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned OBJ_LATENCY = 1,
  parameter rgb332_t     BG_COLOR    = 8'h00
) (
  input  logic        CLK,
  input  logic        RESETn,
  output logic [10:0] oCoord_X,
  output logic [10:0] oCoord_Y,
  input  logic        drawing_request,
  input  logic [7:0]  mVGA_RGB,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_END  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_END  = coord_t'(V_ACTIVE);
  localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t  h_cnt;
  coord_t  v_cnt;
  logic    hs_raw;
  logic    vs_raw;
  logic    act_raw;
  logic    hs_dly;
  logic    vs_dly;
  logic    act_dly;
  rgb332_t pix_sel;
  rgb888_t pix_888;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign oCoord_X = h_cnt;
  assign oCoord_Y = v_cnt;

  always_comb begin
    hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    act_raw = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  end

  // Timing bits wait here until the object layer's answer for the same
  // coordinate arrives, so both meet in the output register together.
  vga_delay_line #(
    .DEPTH (OBJ_LATENCY),
    .WIDTH (3),
    .INIT  (3'b110)
  ) u_align (
    .CLK    (CLK),
    .RESETn (RESETn),
    .d      ({hs_raw, vs_raw, act_raw}),
    .q      ({hs_dly, vs_dly, act_dly})
  );

  always_comb begin
    pix_sel = '0;
    if (act_dly) pix_sel = drawing_request ? mVGA_RGB : BG_COLOR;
    pix_888 = rgb332_to_888(pix_sel);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      VGA_R       <= pix_888.r;
      VGA_G       <= pix_888.g;
      VGA_B       <= pix_888.b;
      VGA_HS      <= hs_dly;
      VGA_VS      <= vs_dly;
      VGA_BLANK_N <= act_dly;
      frame_tick  <= (h_cnt == '0) && (v_cnt == V_ACT_END);
    end
  end

endmodule
